io_bus_router: RTL and testbench
================================

// Module: io_bus_router
// PURPOSE
//  Parametrised IO-bus fabric between the core's io_bus master and NUM_SLOTS peripherals.
//  Replaces broadcast strobes with per-slot decoded strobes, using base/mask matching.
//  Holds a bank of board-level output registers (LEDs, hex digits) and returns read data
//  through a registered mux. Counts accesses to unmapped addresses for debug.
// PARAMETERS
//  NUM_SLOTS        5                       number of peripheral slots (1..16)
//  SLOT_BASE        {'h40,'hc0,'h80,'h180,'h240}  per-slot base address, scalar_t each
//  SLOT_MASK        {5{32'hffffffc0}}       per-slot address mask, scalar_t each
//  LOCAL_BASE       'h00                    address of local register 0; reg k at LOCAL_BASE+4k
//  NUM_LOCAL_REGS   6                       number of local output registers (1..16)
//  LOCAL_WIDTH      18                      stored width of each local register
//  LOCAL_RESET      '0                      reset value of every local register
//  STATUS_ADDR      'h3fc                   unmapped-access counter register address
//  UNMAPPED_VALUE   32'hffffffff            read data returned for unmapped reads
//  ERR_COUNT_WIDTH  16                      width of the unmapped-access counter
// PORTS
//  clk              in   1                  system clock
//  reset            in   1                  asynchronous, active-high reset
//  io_bus_m         io_bus_interface (slave side)  request from core: write_en, read_en, adress, write_data; read_data returned
//  peripheral_io_bus[NUM_SLOTS]  io_bus_interface (master side)  one per peripheral slot
//  local_reg_out    out  NUM_LOCAL_REGS x LOCAL_WIDTH  local register contents
//  unmapped_access  out  1                  one-cycle pulse, registered, on each unmapped access
// BEHAVIOUR
//  Decode (combinational): slot i hits when (adress & SLOT_MASK[i]) == SLOT_BASE[i].
//   On overlap, the lowest index wins. A local hit or STATUS_ADDR hit overrides any slot hit.
//  Forwarding: adress and write_data are broadcast to all slots.
//   write_en/read_en are asserted the same cycle, only on the winning slot; all others see 0.
//  Read return: 1-cycle latency. On read_en, read_source <= winning target
//   (slot i, LOCAL k, STATUS or UNMAPPED).
//   io_bus_m.read_data in the next cycle:
//    - slot: muxes that slot's read_data.
//    - LOCAL: registered value zero-extended from LOCAL_WIDTH.
//    - STATUS: counter zero-extended.
//    - UNMAPPED: UNMAPPED_VALUE.
//   read_source holds when read_en=0, so read_data keeps tracking the last source.
//  Local writes: reg k <= write_data[LOCAL_WIDTH-1:0]; upper bits are dropped.
//   A local read in the same cycle as a write to the same register returns the old value.
//  STATUS write (any data): clears the counter to 0.
//   A STATUS access is mapped, so clear and increment never coincide.
//  Unmapped access (read_en|write_en, no hit): counter +1, saturating at all-ones.
//   unmapped_access = 1 the next cycle. read_en&write_en together count once.
//   Unmapped writes are dropped.
//  Reset values:
//   - local regs = LOCAL_RESET
//   - counter = 0
//   - unmapped_access = 0
//   - read_source = UNMAPPED, so read_data = UNMAPPED_VALUE
//  Reset mid-read: the pending return is discarded; the first post-reset read_data is UNMAPPED_VALUE.
//  Back-to-back reads on consecutive cycles are supported; each returns exactly one cycle after its read_en.
//  Elaboration: $error if NUM_SLOTS or NUM_LOCAL_REGS is out of range,
//   or if STATUS_ADDR lies inside the local register window.
// STRUCTURE
//  defines package: the io_target_t struct {kind: SLOT/LOCAL/STATUS/UNMAPPED, index}.
//   UNMAPPED_VALUE default is a named constant there.
//  Sub-module io_address_decoder: pure combinational; adress -> io_target_t, priority as above.
//   It is reused by future multi-master fabrics.
//  io_bus_router holds the strobe gating, local registers, counter, read_source and output mux.
// TESTING
//  1. Reset, then read 'h00 -> read_data 0 next cycle.
//     A read straight after reset with no request -> read_data 32'hffffffff.
//  2. Write 'h00 data 32'hfffc_1234 -> local_reg_out[0] = 18'h01234.
//     Read 'h00 -> 32'h0000_1234 one cycle later.
//  3. Read 'hc4 -> only peripheral_io_bus[1].read_en=1 that cycle.
//     Slot 1 drives 'hcafe -> io_bus_m.read_data = 'hcafe next cycle.
//  4. Write 'h300 (unmapped) -> no slot strobe, unmapped_access pulses, STATUS reads 1.
//     Write STATUS -> reads 0.
//  5. 2^16+3 unmapped reads -> STATUS saturates at 'hffff; every read returns 32'hffffffff.
//  6. Overlap config SLOT_BASE[0]=SLOT_BASE[2]: access hits slot 0 only.
//     Assert reset during an outstanding read -> no strobe leak, read_data = UNMAPPED_VALUE.

Source files
------------

// File: rtl/io_bus_router_pkg.sv
// Shared types and constants for the IO-bus router fabric and its address decoder.
package io_bus_router_pkg;

  typedef logic [31:0] scalar_t;

  // Which class of target an address resolves to.
  typedef enum logic [1:0] {
    TGT_SLOT     = 2'd0,
    TGT_LOCAL    = 2'd1,
    TGT_STATUS   = 2'd2,
    TGT_UNMAPPED = 2'd3
  } target_kind_t;

  // Decoded target: kind plus slot or local-register index (unused for STATUS/UNMAPPED).
  typedef struct packed {
    target_kind_t kind;
    logic [3:0]   index;
  } io_target_t;

  localparam scalar_t    UNMAPPED_VALUE_DEFAULT = 32'hffff_ffff;
  localparam io_target_t TARGET_UNMAPPED        = '{kind: TGT_UNMAPPED, index: 4'd0};

endpackage

// File: rtl/io_address_decoder.sv
// Pure combinational address decoder: maps an io_bus address onto a slot, a local
// register, the status counter, or nothing. Local/status hits beat slot hits, and
// among overlapping slots the lowest index wins.
module io_address_decoder
  import io_bus_router_pkg::*;
#(
  parameter int                         NUM_SLOTS      = 1,
  parameter logic [NUM_SLOTS-1:0][31:0] SLOT_BASE      = '0,
  parameter logic [NUM_SLOTS-1:0][31:0] SLOT_MASK      = '1,
  parameter scalar_t                    LOCAL_BASE     = 32'h0,
  parameter int                         NUM_LOCAL_REGS = 1,
  parameter scalar_t                    STATUS_ADDR    = 32'h3fc
) (
  input  scalar_t    adress_i,
  output io_target_t target_o
);

  scalar_t local_off;

  // Priority resolution; the descending slot loop leaves the lowest matching index last.
  always_comb begin
    target_o  = TARGET_UNMAPPED;
    local_off = adress_i - LOCAL_BASE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if ((adress_i & SLOT_MASK[i]) == SLOT_BASE[i]) begin
        target_o.kind  = TGT_SLOT;
        target_o.index = 4'(i);
      end
    end
    // Local registers are word-spaced; an address below LOCAL_BASE wraps and misses.
    if ((local_off[1:0] == 2'b00) && (local_off < scalar_t'(4 * NUM_LOCAL_REGS))) begin
      target_o.kind  = TGT_LOCAL;
      target_o.index = local_off[5:2];
    end
    if (adress_i == STATUS_ADDR) begin
      target_o.kind  = TGT_STATUS;
      target_o.index = 4'd0;
    end
  end

endmodule

// File: rtl/io_bus_router.sv
// IO-bus fabric: per-slot decoded strobes, a bank of board-level output registers,
// an unmapped-access counter, and a one-cycle-latency read-return mux.
module io_bus_router
  import io_bus_router_pkg::*;
#(
  parameter int                         NUM_SLOTS       = 5,
  parameter logic [NUM_SLOTS-1:0][31:0] SLOT_BASE       = {32'h240, 32'h180, 32'h80, 32'hc0, 32'h40},
  parameter logic [NUM_SLOTS-1:0][31:0] SLOT_MASK       = {5{32'hffff_ffc0}},
  parameter scalar_t                    LOCAL_BASE      = 32'h0,
  parameter int                         NUM_LOCAL_REGS  = 6,
  parameter int                         LOCAL_WIDTH     = 18,
  parameter logic [LOCAL_WIDTH-1:0]     LOCAL_RESET     = '0,
  parameter scalar_t                    STATUS_ADDR     = 32'h3fc,
  parameter scalar_t                    UNMAPPED_VALUE  = UNMAPPED_VALUE_DEFAULT,
  parameter int                         ERR_COUNT_WIDTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  // master side (from core)
  input  logic                                        io_bus_m_write_en,
  input  logic                                        io_bus_m_read_en,
  input  scalar_t                                     io_bus_m_adress,
  input  scalar_t                                     io_bus_m_write_data,
  output scalar_t                                     io_bus_m_read_data,
  // peripheral slots
  output logic [NUM_SLOTS-1:0]                        peripheral_write_en,
  output logic [NUM_SLOTS-1:0]                        peripheral_read_en,
  output logic [NUM_SLOTS-1:0][31:0]                  peripheral_adress,
  output logic [NUM_SLOTS-1:0][31:0]                  peripheral_write_data,
  input  logic [NUM_SLOTS-1:0][31:0]                  peripheral_read_data,
  // board outputs and debug
  output logic [NUM_LOCAL_REGS-1:0][LOCAL_WIDTH-1:0]  local_reg_out,
  output logic                                        unmapped_access
);

  // Handshake: the bus has no stall. A request is a single cycle with read_en and/or
  // write_en high; the winning slot sees its strobe in that same cycle, and read data
  // is presented on io_bus_m_read_data exactly one cycle after read_en.

  if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_bad_slots
    $error("io_bus_router: NUM_SLOTS must be 1..16");
  end
  if (NUM_LOCAL_REGS < 1 || NUM_LOCAL_REGS > 16) begin : g_bad_locals
    $error("io_bus_router: NUM_LOCAL_REGS must be 1..16");
  end
  if ((STATUS_ADDR >= LOCAL_BASE) &&
      (STATUS_ADDR < LOCAL_BASE + scalar_t'(4 * NUM_LOCAL_REGS))) begin : g_bad_status
    $error("io_bus_router: STATUS_ADDR overlaps the local register window");
  end

  io_target_t                                  target;
  logic                                        access;
  logic [NUM_SLOTS-1:0]                        slot_sel;
  io_target_t                                  read_source_q, read_source_d;
  scalar_t                                     rdata_q, rdata_d;
  logic [NUM_LOCAL_REGS-1:0][LOCAL_WIDTH-1:0]  local_q, local_d;
  logic [ERR_COUNT_WIDTH-1:0]                  err_cnt_q, err_cnt_d;
  logic                                        unmapped_q, unmapped_d;

  io_address_decoder #(
    .NUM_SLOTS      (NUM_SLOTS),
    .SLOT_BASE      (SLOT_BASE),
    .SLOT_MASK      (SLOT_MASK),
    .LOCAL_BASE     (LOCAL_BASE),
    .NUM_LOCAL_REGS (NUM_LOCAL_REGS),
    .STATUS_ADDR    (STATUS_ADDR)
  ) u_decoder (
    .adress_i (io_bus_m_adress),
    .target_o (target)
  );

  assign access = io_bus_m_read_en | io_bus_m_write_en;

  // Broadcast address/data; gate strobes to the winning slot only, and never during reset.
  always_comb begin
    slot_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      peripheral_adress[i]     = io_bus_m_adress;
      peripheral_write_data[i] = io_bus_m_write_data;
      slot_sel[i]              = !reset && (target.kind == TGT_SLOT) && (target.index == 4'(i));
    end
    peripheral_write_en = slot_sel & {NUM_SLOTS{io_bus_m_write_en}};
    peripheral_read_en  = slot_sel & {NUM_SLOTS{io_bus_m_read_en}};
  end

  // Next state of local registers, counter, pulse, read source and captured read data.
  always_comb begin
    local_d       = local_q;
    err_cnt_d     = err_cnt_q;
    unmapped_d    = 1'b0;
    read_source_d = read_source_q;
    rdata_d       = rdata_q;
    if (io_bus_m_write_en && (target.kind == TGT_LOCAL)) begin
      for (int k = 0; k < NUM_LOCAL_REGS; k++) begin
        if (target.index == 4'(k)) local_d[k] = io_bus_m_write_data[LOCAL_WIDTH-1:0];
      end
    end
    if (io_bus_m_write_en && (target.kind == TGT_STATUS)) begin
      err_cnt_d = '0;
    end
    if (access && (target.kind == TGT_UNMAPPED)) begin
      unmapped_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_COUNT_WIDTH'(1);
    end
    // Local/status data is captured at the read, so a same-cycle write is not visible.
    if (io_bus_m_read_en) begin
      read_source_d = target;
      rdata_d       = '0;
      if (target.kind == TGT_LOCAL) begin
        for (int k = 0; k < NUM_LOCAL_REGS; k++) begin
          if (target.index == 4'(k)) rdata_d[LOCAL_WIDTH-1:0] = local_q[k];
        end
      end
      if (target.kind == TGT_STATUS) rdata_d[ERR_COUNT_WIDTH-1:0] = err_cnt_q;
    end
  end

  // State registers; reset discards any pending read return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_q       <= {NUM_LOCAL_REGS{LOCAL_RESET}};
      err_cnt_q     <= '0;
      unmapped_q    <= 1'b0;
      read_source_q <= TARGET_UNMAPPED;
      rdata_q       <= '0;
    end else begin
      local_q       <= local_d;
      err_cnt_q     <= err_cnt_d;
      unmapped_q    <= unmapped_d;
      read_source_q <= read_source_d;
      rdata_q       <= rdata_d;
    end
  end

  // Read-return mux: slots are passed through live, others come from captured data.
  always_comb begin
    io_bus_m_read_data = UNMAPPED_VALUE;
    case (read_source_q.kind)
      TGT_SLOT: begin
        io_bus_m_read_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (read_source_q.index == 4'(i)) io_bus_m_read_data = peripheral_read_data[i];
        end
      end
      TGT_LOCAL, TGT_STATUS: io_bus_m_read_data = rdata_q;
      default:               io_bus_m_read_data = UNMAPPED_VALUE;
    endcase
  end

  assign local_reg_out   = local_q;
  assign unmapped_access = unmapped_q;

endmodule

// File: tb/tb_io_bus_router.sv
// Testbench for io_bus_router: table of single-cycle bus requests with hand-derived
// expected strobes/pulses, a read-data expectation queue, and hand-written sequences
// for counter saturation, slot overlap and reset during a read.
module tb_io_bus_router;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        m_we, m_re;
  logic [31:0] m_addr, m_wdata;
  logic [4:0][31:0] slot_rd;

  logic [31:0]       dut_rd;
  logic [4:0]        dut_ws, dut_rs;
  logic [4:0][31:0]  dut_padr, dut_pwd;
  logic [5:0][17:0]  dut_lr;
  logic              dut_um;

  logic [31:0]       ov_rd;
  logic [4:0]        ov_ws, ov_rs;
  logic [4:0][31:0]  ov_padr, ov_pwd;
  logic [5:0][17:0]  ov_lr;
  logic              ov_um;

  io_bus_router dut (
    .clk                   (clk),
    .reset                 (reset),
    .io_bus_m_write_en     (m_we),
    .io_bus_m_read_en      (m_re),
    .io_bus_m_adress       (m_addr),
    .io_bus_m_write_data   (m_wdata),
    .io_bus_m_read_data    (dut_rd),
    .peripheral_write_en   (dut_ws),
    .peripheral_read_en    (dut_rs),
    .peripheral_adress     (dut_padr),
    .peripheral_write_data (dut_pwd),
    .peripheral_read_data  (slot_rd),
    .local_reg_out         (dut_lr),
    .unmapped_access       (dut_um)
  );

  // Overlapping configuration: slot 2 shares slot 0's base.
  io_bus_router #(
    .SLOT_BASE ({32'h240, 32'h180, 32'h40, 32'hc0, 32'h40})
  ) dut_ov (
    .clk                   (clk),
    .reset                 (reset),
    .io_bus_m_write_en     (m_we),
    .io_bus_m_read_en      (m_re),
    .io_bus_m_adress       (m_addr),
    .io_bus_m_write_data   (m_wdata),
    .io_bus_m_read_data    (ov_rd),
    .peripheral_write_en   (ov_ws),
    .peripheral_read_en    (ov_rs),
    .peripheral_adress     (ov_padr),
    .peripheral_write_data (ov_pwd),
    .peripheral_read_data  (slot_rd),
    .local_reg_out         (ov_lr),
    .unmapped_access       (ov_um)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  exp_rs;
    logic [4:0]  exp_ws;
    logic        exp_um;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] exp_rs,
                         input logic [4:0] exp_ws, input logic exp_um,
                         input logic [31:0] exp_rd);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.exp_rs = exp_rs; v.exp_ws = exp_ws; v.exp_um = exp_um; v.exp_rd = exp_rd;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // One bus cycle: drive at negedge, check strobes, then check return/pulse after posedge.
  task automatic step(input vec_t v, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    m_we = v.we; m_re = v.re; m_addr = v.addr; m_wdata = v.wdata;
    #1;
    chk({tag, "_rd_strobe"}, {27'b0, dut_rs}, {27'b0, v.exp_rs});
    chk({tag, "_wr_strobe"}, {27'b0, dut_ws}, {27'b0, v.exp_ws});
    if (v.re) exp_q.push_back(v.exp_rd);
    @(posedge clk);
    #1;
    if (v.re) begin
      exp = exp_q.pop_front();
      chk({tag, "_rdata"}, dut_rd, exp);
    end
    chk({tag, "_unmapped_pulse"}, {31'b0, dut_um}, {31'b0, v.exp_um});
    @(negedge clk);
    m_we = 1'b0; m_re = 1'b0;
  endtask

  task automatic idle_bus();
    m_we = 1'b0; m_re = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   exp_cnt;

    for (int i = 0; i < 5; i++) slot_rd[i] = 32'h1000_0000 | 32'(i);
    slot_rd[1] = 32'h0000_cafe;

    //      we    re    addr          wdata          rs        ws        um    rd
    add_vec(1'b0, 1'b1, 32'h000, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h000, 32'hfffc_1234,  5'b00000, 5'b00000, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 32'h000, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_1234);
    add_vec(1'b0, 1'b1, 32'h0c4, 32'h0,          5'b00010, 5'b00000, 1'b0, 32'h0000_cafe);
    add_vec(1'b1, 1'b0, 32'h044, 32'h1,          5'b00000, 5'b00001, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 32'h080, 32'h0,          5'b00100, 5'b00000, 1'b0, 32'h1000_0002);
    add_vec(1'b0, 1'b1, 32'h1a0, 32'h0,          5'b01000, 5'b00000, 1'b0, 32'h1000_0003);
    add_vec(1'b1, 1'b0, 32'h27c, 32'h5,          5'b00000, 5'b10000, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 32'h300, 32'hdead,       5'b00000, 5'b00000, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 32'h3fc, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_0001);
    add_vec(1'b1, 1'b0, 32'h3fc, 32'h1234,       5'b00000, 5'b00000, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 32'h3fc, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 1'b1, 32'h304, 32'h0,          5'b00000, 5'b00000, 1'b1, 32'hffff_ffff);
    add_vec(1'b1, 1'b1, 32'h308, 32'h7,          5'b00000, 5'b00000, 1'b1, 32'hffff_ffff);
    add_vec(1'b0, 1'b1, 32'h3fc, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_0002);
    add_vec(1'b1, 1'b0, 32'h014, 32'h0003_ffff,  5'b00000, 5'b00000, 1'b0, 32'h0);
    add_vec(1'b1, 1'b1, 32'h014, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0003_ffff);
    add_vec(1'b0, 1'b1, 32'h014, 32'h0,          5'b00000, 5'b00000, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 1'b1, 32'h018, 32'h0,          5'b00000, 5'b00000, 1'b1, 32'hffff_ffff);

    // reset
    idle_bus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_rdata", dut_rd, 32'hffff_ffff);
    chk("reset_unmapped", {31'b0, dut_um}, 32'h0);
    chk("reset_local0", {14'b0, dut_lr[0]}, 32'h0);
    chk("reset_local5", {14'b0, dut_lr[5]}, 32'h0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    chk("local0_out", {14'b0, dut_lr[0]}, 32'h0000_1234);
    chk("local5_out", {14'b0, dut_lr[5]}, 32'h0);
    chk("read_hold_unmapped", dut_rd, 32'hffff_ffff);

    // broadcast of address/data to all slots
    @(negedge clk);
    m_addr = 32'h0000_0abc; m_wdata = 32'h5a5a_0101;
    #1;
    chk("adr_bcast", dut_padr[3], 32'h0000_0abc);
    chk("wdata_bcast", dut_pwd[0], 32'h5a5a_0101);
    idle_bus();

    // counter saturation
    v.we = 1'b1; v.re = 1'b0; v.addr = 32'h3fc; v.wdata = 32'h0;
    v.exp_rs = '0; v.exp_ws = '0; v.exp_um = 1'b0; v.exp_rd = 32'h0;
    step(v, "sat_clear");
    exp_cnt = 0;
    for (int i = 0; i < 65536 + 3; i++) begin
      v.we = 1'b0; v.re = 1'b1; v.addr = 32'h300; v.exp_um = 1'b1; v.exp_rd = 32'hffff_ffff;
      step(v, "sat_unmapped");
      exp_cnt = (exp_cnt >= 32'hffff) ? 32'hffff : exp_cnt + 1;
    end
    v.we = 1'b0; v.re = 1'b1; v.addr = 32'h3fc; v.exp_um = 1'b0; v.exp_rd = 32'(exp_cnt);
    step(v, "sat_status");

    // overlap configuration: lowest slot index wins
    @(negedge clk);
    m_re = 1'b1; m_addr = 32'h48;
    #1;
    chk("ov_rd_strobe", {27'b0, ov_rs}, 32'h0000_0001);
    @(posedge clk);
    #1;
    chk("ov_rdata", ov_rd, 32'h1000_0000);
    @(negedge clk);
    m_re = 1'b0; m_we = 1'b1; m_addr = 32'h7c;
    #1;
    chk("ov_wr_strobe", {27'b0, ov_ws}, 32'h0000_0001);
    @(negedge clk);
    idle_bus();

    // reset during an outstanding read
    @(negedge clk);
    m_re = 1'b1; m_addr = 32'h0c4;
    #1;
    chk("pre_rst_strobe", {27'b0, dut_rs}, 32'h0000_0002);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_strobe_leak", {27'b0, dut_rs}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_read_rdata", dut_rd, 32'hffff_ffff);
    @(negedge clk);
    idle_bus();
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("post_rst_rdata", dut_rd, 32'hffff_ffff);
    chk("post_rst_local0", {14'b0, dut_lr[0]}, 32'h0);
    v.we = 1'b0; v.re = 1'b1; v.addr = 32'h3fc; v.exp_rs = '0; v.exp_ws = '0;
    v.exp_um = 1'b0; v.exp_rd = 32'h0;
    step(v, "post_rst_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
